// File: rtl/fpcvt_pkg.sv
// Shared definitions for the FP16-to-integer converter: field widths,
// rounding-mode encodings and the inter-stage payload structs.
package fpcvt_pkg;

   localparam int unsigned EXP_W = 5;
   localparam int unsigned MAN_W = 10;
   localparam int unsigned BIAS  = 15;
   localparam int unsigned MAG_W = 17;

   typedef enum logic [1:0] {
      RM_RNE = 2'd0,
      RM_RTZ = 2'd1,
      RM_RUP = 2'd2,
      RM_RDN = 2'd3
   } rmode_t;

   typedef struct packed {
      logic             sign;
      logic             nan;
      logic             sat;
      logic [MAG_W-1:0] mag;
      logic             guard;
      logic             sticky;
      rmode_t           rmode;
   } align_t;

   typedef struct packed {
      logic           sign;
      logic           nan;
      logic           sat;
      logic [MAG_W:0] mag;
      logic           inexact;
   } round_t;

endpackage

// File: rtl/fpcvt_round.sv
// Rounding increment decision from sign, integer LSB, guard and sticky bits.
module fpcvt_round
   import fpcvt_pkg::*;
(
   input  logic   sign,
   input  logic   lsb,
   input  logic   guard,
   input  logic   sticky,
   input  rmode_t rmode,
   output logic   inc
);

   always_comb begin
      inc = 1'b0;
      case (rmode)
         RM_RNE:  inc = guard & (sticky | lsb);
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RDN:  inc = sign & (guard | sticky);
         default: inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp16_to_int_pipe.sv
// Three-stage FP16 to signed OUT_W-bit integer converter (align, round, clamp)
// with a single global stall enable driven by the output handshake.
module fp16_to_int_pipe
   import fpcvt_pkg::*;
#(
   parameter int unsigned OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic [1:0]       in_rmode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic             out_inexact,
   output logic             out_invalid
);

   localparam logic signed [6:0] BIAS_S  = 7'(BIAS);
   localparam logic [MAG_W:0]    POS_MAX = 18'((1 << (OUT_W - 1)) - 1);
   localparam logic [MAG_W:0]    NEG_MAG = 18'(1 << (OUT_W - 1));
   localparam logic [OUT_W-1:0]  MAX_V   = {1'b0, {(OUT_W - 1){1'b1}}};
   localparam logic [OUT_W-1:0]  MIN_V   = {1'b1, {(OUT_W - 1){1'b0}}};

   logic             en;
   logic             v1, v2;
   align_t           a_d, a_q;
   round_t           r_d, r_q;
   logic             inc;
   logic [EXP_W-1:0] e;
   logic [MAN_W-1:0] man;
   logic [MAN_W:0]   sig;
   logic signed [6:0] ex;
   logic [4:0]       sh;
   logic [34:0]      wide;
   logic [OUT_W-1:0] data_d, mag_t;
   logic             ovf_d, inx_d, inv_d;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // Align: integer magnitude from the significand; right shifts keep the
   // first dropped bit as guard and OR the remainder into sticky.
   always_comb begin
      e    = in_data[14:10];
      man  = in_data[9:0];
      sig  = {|e, man};
      ex   = (e == '0) ? (7'sd1 - BIAS_S) : ($signed({2'b00, e}) - BIAS_S);
      sh   = '0;
      wide = '0;
      a_d       = '0;
      a_d.sign  = in_data[15];
      a_d.rmode = rmode_t'(in_rmode);
      a_d.nan   = (&e) & (|man);
      a_d.sat   = (ex >= 7'sd16) & ~a_d.nan;
      if (ex >= 7'sd10) begin
         sh      = 5'(ex - 7'sd10);
         a_d.mag = {6'b0, sig} << sh;
      end else begin
         sh         = 5'(7'sd10 - ex);
         wide       = {sig, 24'b0} >> sh;
         a_d.mag    = {6'b0, wide[34:24]};
         a_d.guard  = wide[23];
         a_d.sticky = |wide[22:0];
      end
   end

   fpcvt_round u_round (
      .sign   (a_q.sign),
      .lsb    (a_q.mag[0]),
      .guard  (a_q.guard),
      .sticky (a_q.sticky),
      .rmode  (a_q.rmode),
      .inc    (inc)
   );

   always_comb begin
      r_d         = '0;
      r_d.sign    = a_q.sign;
      r_d.nan     = a_q.nan;
      r_d.sat     = a_q.sat;
      r_d.mag     = {1'b0, a_q.mag} + {{MAG_W{1'b0}}, inc};
      r_d.inexact = a_q.guard | a_q.sticky;
   end

   // Clamp: negative side allows one extra magnitude step (two's-complement min).
   always_comb begin
      data_d = '0;
      mag_t  = '0;
      ovf_d  = 1'b0;
      inx_d  = 1'b0;
      inv_d  = 1'b0;
      if (r_q.nan) begin
         inv_d = 1'b1;
      end else if (!r_q.sign && (r_q.sat || r_q.mag > POS_MAX)) begin
         data_d = MAX_V;
         ovf_d  = 1'b1;
      end else if (r_q.sign && (r_q.sat || r_q.mag > NEG_MAG)) begin
         data_d = MIN_V;
         ovf_d  = 1'b1;
      end else begin
         mag_t  = r_q.mag[OUT_W-1:0];
         data_d = r_q.sign ? -mag_t : mag_t;
         inx_d  = r_q.inexact;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         a_q         <= '0;
         r_q         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_ovf     <= 1'b0;
         out_inexact <= 1'b0;
         out_invalid <= 1'b0;
      end else if (en) begin
         v1          <= in_valid;
         a_q         <= a_d;
         v2          <= v1;
         r_q         <= r_d;
         out_valid   <= v2;
         out_data    <= data_d;
         out_ovf     <= ovf_d;
         out_inexact <= inx_d;
         out_invalid <= inv_d;
      end
   end

endmodule
